// File: rtl/break_phase_sequencer.sv
// Sequences one WalkSAT break/select phase: fetch each candidate's clause data,
// pulse its one-hot write slot, then issue the all-ones select and return the winner.
module break_phase_sequencer #(
  parameter int NSAT        = 3,
  parameter int NSAT_BITS   = 2,
  parameter int VAR_BITS    = 16,
  parameter int BVC_LATENCY = 2,
  parameter int SEL_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic [NSAT*VAR_BITS-1:0] var_ids_i,
  output logic                     busy_o,
  output logic                     fetch_req_o,
  output logic [VAR_BITS-1:0]      fetch_var_o,
  input  logic                     fetch_ack_i,
  output logic [NSAT_BITS-1:0]     wren_o,
  output logic [NSAT-1:0]          bv_valid_o,
  input  logic [NSAT_BITS-1:0]     select_i,
  output logic                     done_o,
  output logic [NSAT_BITS-1:0]     flip_idx_o,
  output logic [VAR_BITS-1:0]      flip_var_o,
  output logic                     none_valid_o
);

  localparam int LAT_MAX = (BVC_LATENCY > SEL_LATENCY) ? BVC_LATENCY : SEL_LATENCY;
  localparam int LAT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam int K_W     = (NSAT > 1) ? $clog2(NSAT) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, WRITE, SELECT, SEL_WAIT, DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [K_W-1:0]           k_q, k_d;
  logic [LAT_W-1:0]         lat_q, lat_d;
  logic [NSAT*VAR_BITS-1:0] ids_q, ids_d;
  logic [NSAT-1:0]          valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic                     fetch_req_q, fetch_req_d;
  logic [VAR_BITS-1:0]      fetch_var_q, fetch_var_d;
  logic [NSAT_BITS-1:0]     wren_q, wren_d;
  logic                     done_q, done_d;
  logic [NSAT_BITS-1:0]     flip_idx_q, flip_idx_d;
  logic [VAR_BITS-1:0]      flip_var_q, flip_var_d;
  logic                     none_q, none_d;

  logic [NSAT-1:0]          valid_in;
  logic                     enter_step, enter_write;
  logic [K_W-1:0]           step_k;

  always_comb begin
    valid_in = '0;
    for (int i = 0; i < NSAT; i++) begin
      valid_in[i] = |var_ids_i[i*VAR_BITS +: VAR_BITS];
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    lat_d       = lat_q;
    ids_d       = ids_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    fetch_req_d = 1'b0;
    fetch_var_d = fetch_var_q;
    wren_d      = '0;
    done_d      = 1'b0;
    flip_idx_d  = flip_idx_q;
    flip_var_d  = flip_var_q;
    none_d      = none_q;
    enter_step  = 1'b0;
    enter_write = 1'b0;
    step_k      = k_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          ids_d   = var_ids_i;
          valid_d = valid_in;
          busy_d  = 1'b1;
          k_d     = '0;
          if (valid_in == '0) begin
            state_d = DONE;
          end else begin
            enter_step = 1'b1;
            step_k     = '0;
          end
        end
      end
      // A FETCH cycle with no request outstanding is the one-cycle skip of an empty slot.
      FETCH: begin
        if (!fetch_req_q) begin
          enter_step = 1'b1;
          step_k     = k_q + 1'b1;
        end else if (fetch_ack_i) begin
          if (BVC_LATENCY > 1) begin
            state_d = WAIT;
            lat_d   = LAT_W'(BVC_LATENCY - 2);
          end else begin
            enter_write = 1'b1;
          end
        end else begin
          fetch_req_d = 1'b1;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          enter_write = 1'b1;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      WRITE: begin
        enter_step = 1'b1;
        step_k     = k_q + 1'b1;
      end
      SELECT: begin
        state_d = SEL_WAIT;
        lat_d   = LAT_W'(SEL_LATENCY - 1);
      end
      SEL_WAIT: begin
        if (lat_q == '0) begin
          state_d    = DONE;
          done_d     = 1'b1;
          none_d     = 1'b0;
          flip_idx_d = select_i;
          flip_var_d = '0;
          for (int i = 0; i < NSAT; i++) begin
            if (select_i == NSAT_BITS'(i) && valid_q[i]) begin
              flip_var_d = ids_q[i*VAR_BITS +: VAR_BITS];
            end
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      DONE: begin
        // Entered without done_o only from IDLE when every slot is empty.
        if (done_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          done_d     = 1'b1;
          none_d     = 1'b1;
          flip_idx_d = '0;
          flip_var_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_write) begin
      if (k_q == K_W'(NSAT - 1)) begin
        state_d = SELECT;
        wren_d  = '1;
      end else begin
        state_d = WRITE;
        wren_d  = NSAT_BITS'(1) << k_q;
      end
    end

    if (enter_step) begin
      k_d = step_k;
      if (valid_d[step_k]) begin
        state_d     = FETCH;
        fetch_req_d = 1'b1;
        fetch_var_d = ids_d[step_k*VAR_BITS +: VAR_BITS];
      end else if (step_k == K_W'(NSAT - 1)) begin
        state_d = SELECT;
        wren_d  = '1;
      end else begin
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      lat_q       <= '0;
      ids_q       <= '0;
      valid_q     <= '0;
      busy_q      <= 1'b0;
      fetch_req_q <= 1'b0;
      fetch_var_q <= '0;
      wren_q      <= '0;
      done_q      <= 1'b0;
      flip_idx_q  <= '0;
      flip_var_q  <= '0;
      none_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      lat_q       <= lat_d;
      ids_q       <= ids_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      fetch_req_q <= fetch_req_d;
      fetch_var_q <= fetch_var_d;
      wren_q      <= wren_d;
      done_q      <= done_d;
      flip_idx_q  <= flip_idx_d;
      flip_var_q  <= flip_var_d;
      none_q      <= none_d;
    end
  end

  assign busy_o       = busy_q;
  assign fetch_req_o  = fetch_req_q;
  assign fetch_var_o  = fetch_var_q;
  assign wren_o       = wren_q;
  assign bv_valid_o   = valid_q;
  assign done_o       = done_q;
  assign flip_idx_o   = flip_idx_q;
  assign flip_var_o   = flip_var_q;
  assign none_valid_o = none_q;

endmodule

// File: tb/tb_break_phase_sequencer.sv
// Bench for break_phase_sequencer: cycle-stamped expected events are queued per phase
// and compared in order as the DUT emits fetches, wren pulses and done.
module tb_break_phase_sequencer;
  localparam int NSAT = 3;
  localparam int NB   = 2;
  localparam int VB   = 16;
  localparam int BVC  = 2;
  localparam int SEL  = 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start_i;
  logic [NSAT*VB-1:0]   var_ids_i;
  logic                 busy_o;
  logic                 fetch_req_o;
  logic [VB-1:0]        fetch_var_o;
  logic                 fetch_ack_i;
  logic [NB-1:0]        wren_o;
  logic [NSAT-1:0]      bv_valid_o;
  logic [NB-1:0]        select_i;
  logic                 done_o;
  logic [NB-1:0]        flip_idx_o;
  logic [VB-1:0]        flip_var_o;
  logic                 none_valid_o;

  break_phase_sequencer #(
    .NSAT(NSAT), .NSAT_BITS(NB), .VAR_BITS(VB), .BVC_LATENCY(BVC), .SEL_LATENCY(SEL)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .var_ids_i(var_ids_i),
    .busy_o(busy_o), .fetch_req_o(fetch_req_o), .fetch_var_o(fetch_var_o),
    .fetch_ack_i(fetch_ack_i), .wren_o(wren_o), .bv_valid_o(bv_valid_o),
    .select_i(select_i), .done_o(done_o), .flip_idx_o(flip_idx_o),
    .flip_var_o(flip_var_o), .none_valid_o(none_valid_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = fetch start (val = var), 1 = non-zero wren (val = wren), 2 = done (val = flip_var)
  typedef struct {
    int kind;
    int cyc;
    int val;
    int idx;
    int none;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic chk_eq(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input int val, input int idx, input int none);
    ev_t e;
    e.kind = kind; e.cyc = c; e.val = val; e.idx = idx; e.none = none;
    exp_q.push_back(e);
  endtask

  // Reference timeline: cycle 1 is the first cycle after start is sampled.
  task automatic model(input logic [NSAT*VB-1:0] ids, input int dly [NSAT], input int sel);
    int t;
    int s;
    int w;
    int fv;
    logic [VB-1:0] id;
    t = 1;
    s = 0;
    if (ids == '0) begin
      push_ev(2, 2, 0, 0, 1);
      return;
    end
    for (int k = 0; k < NSAT; k++) begin
      id = ids[k*VB +: VB];
      if (id != 0) begin
        push_ev(0, t, int'(id), 0, 0);
        w = t + dly[k] + BVC;
        push_ev(1, w, (k == NSAT - 1) ? (1 << NB) - 1 : (1 << k), 0, 0);
        t = w + 1;
        if (k == NSAT - 1) s = w;
      end else if (k < NSAT - 1) begin
        t = t + 1;
      end else begin
        push_ev(1, t, (1 << NB) - 1, 0, 0);
        s = t;
      end
    end
    fv = 0;
    if (sel < NSAT) fv = int'(ids[sel*VB +: VB]);
    push_ev(2, s + SEL + 1, fv, sel, 0);
  endtask

  task automatic compare_ev(input int kind, input int rel, input int val, input int idx, input int none);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk_eq($sformatf("unexpected_ev%0d_at_%0d", kind, rel), kind, -1);
      return;
    end
    e = exp_q.pop_front();
    chk_eq("ev_kind", kind, e.kind);
    chk_eq($sformatf("ev%0d_cycle", kind), rel, e.cyc);
    chk_eq($sformatf("ev%0d_value", kind), val, e.val);
    if (kind == 2) begin
      chk_eq("flip_idx", idx, e.idx);
      chk_eq("none_valid", none, e.none);
    end
  endtask

  // Runs one phase from the current negedge; stray >= 0 injects start/ack noise at that
  // cycle, abort_at >= 0 asserts reset at that cycle and checks the cleared outputs.
  task automatic run_phase(input logic [NSAT*VB-1:0] ids, input int d0, input int d1, input int d2,
                           input int sel, input int stray, input int abort_at);
    int dly [NSAT];
    int vslots[$];
    int fidx;
    int fcnt;
    int base;
    int rel;
    int exp_var;
    bit prev_req;
    bit seen_done;
    logic [NSAT-1:0] mask;

    dly = '{d0, d1, d2};
    mask = '0;
    for (int k = 0; k < NSAT; k++) begin
      mask[k] = (ids[k*VB +: VB] != 0);
      if (mask[k]) vslots.push_back(k);
    end
    exp_var = 0;
    if (sel < NSAT) exp_var = int'(ids[sel*VB +: VB]);
    model(ids, dly, sel);

    fidx = 0; fcnt = 0; prev_req = 1'b0; seen_done = 1'b0;
    var_ids_i = ids;
    select_i  = NB'(sel);
    start_i   = 1'b1;
    base      = cyc;

    for (int i = 0; i < 60 && !seen_done; i++) begin
      @(negedge clk);
      rel = cyc - base;
      if (rel == 1) begin
        chk_eq("busy_first", busy_o, 1);
        chk_eq("bv_valid", bv_valid_o, mask);
      end
      if (fetch_req_o && !prev_req) compare_ev(0, rel, int'(fetch_var_o), 0, 0);
      if (fetch_req_o && prev_req && fidx < vslots.size())
        chk_eq("fetch_var_hold", fetch_var_o, ids[vslots[fidx]*VB +: VB]);
      if (wren_o != '0) compare_ev(1, rel, int'(wren_o), 0, 0);
      if (done_o) begin
        compare_ev(2, rel, int'(flip_var_o), int'(flip_idx_o), int'(none_valid_o));
        seen_done = 1'b1;
      end
      prev_req = fetch_req_o;

      if (rel == abort_at) begin
        reset = 1'b1; start_i = 1'b0; fetch_ack_i = 1'b0;
        @(negedge clk);
        chk_eq("rst_busy", busy_o, 0);
        chk_eq("rst_fetch_req", fetch_req_o, 0);
        chk_eq("rst_fetch_var", fetch_var_o, 0);
        chk_eq("rst_wren", wren_o, 0);
        chk_eq("rst_bv_valid", bv_valid_o, 0);
        chk_eq("rst_done", done_o, 0);
        chk_eq("rst_flip_idx", flip_idx_o, 0);
        chk_eq("rst_flip_var", flip_var_o, 0);
        chk_eq("rst_none_valid", none_valid_o, 0);
        reset = 1'b0;
        exp_q.delete();
        return;
      end

      start_i     = (rel == stray);
      fetch_ack_i = 1'b0;
      if (fetch_req_o && fidx < vslots.size()) begin
        if (fcnt == dly[vslots[fidx]]) begin
          fetch_ack_i = 1'b1;
          fcnt = 0;
          fidx++;
        end else begin
          fcnt++;
        end
      end else if (rel == stray) begin
        fetch_ack_i = 1'b1;
      end
    end

    if (!seen_done) chk_eq("done_timeout", 0, 1);
    chk_eq("events_left", exp_q.size(), 0);
    exp_q.delete();
    start_i = 1'b0;
    fetch_ack_i = 1'b0;
    @(negedge clk);
    chk_eq("busy_after_done", busy_o, 0);
    chk_eq("done_one_cycle", done_o, 0);
    chk_eq("flip_var_held", flip_var_o, exp_var);
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; fetch_ack_i = 1'b0; var_ids_i = '0; select_i = '0;
    repeat (3) @(negedge clk);
    chk_eq("init_busy", busy_o, 0);
    chk_eq("init_fetch_req", fetch_req_o, 0);
    chk_eq("init_wren", wren_o, 0);
    chk_eq("init_bv_valid", bv_valid_o, 0);
    chk_eq("init_done", done_o, 0);
    chk_eq("init_flip_idx", flip_idx_o, 0);
    chk_eq("init_flip_var", flip_var_o, 0);
    chk_eq("init_none_valid", none_valid_o, 0);
    reset = 1'b0;
    @(negedge clk);

    run_phase({16'd12, 16'd9, 16'd5}, 0, 0, 0, 1, -1, -1);   // reference trace
    run_phase({16'd12, 16'd9, 16'd5}, 0, 3, 0, 2, -1, -1);   // ack delayed on candidate 1
    run_phase({16'd0, 16'd9, 16'd0}, 0, 0, 0, 1, -1, -1);    // single valid slot
    run_phase({16'd4, 16'd0, 16'd7}, 1, 0, 2, 1, -1, -1);    // select lands on empty slot
    run_phase({16'd0, 16'd0, 16'd0}, 0, 0, 0, 0, -1, -1);    // nothing valid
    run_phase({16'd12, 16'd9, 16'd5}, 2, 0, 1, 3, -1, -1);   // select beyond NSAT
    run_phase({16'd12, 16'd9, 16'd5}, 0, 0, 0, 1, -1, 5);    // reset in WAIT of candidate 1
    run_phase({16'd12, 16'd9, 16'd5}, 0, 0, 0, 1, -1, -1);
    run_phase({16'd12, 16'd9, 16'd5}, 0, 0, 0, 1, 5, -1);    // stray start and ack

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
